// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : N-stage hazard detection for the RV32 pipeline: operand forward
//            selects, load-use stalls and multi-cycle flush bubbles.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_unit #(
   parameter  int REG_W      = 5,
   parameter  int FWD_STAGES = 2,
   parameter  int LOAD_LAT   = 1,
   parameter  int FLUSH_CYC  = 1,
   parameter  int CNT_W      = 16,
   localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] dec_rs1,
   input  logic [REG_W-1:0] dec_rs2,
   input  logic             dec_use_rs1,
   input  logic             dec_use_rs2,
   input  logic [REG_W-1:0] dec_rd,
   input  logic             dec_wr,
   input  logic             dec_is_load,
   input  logic             flush,
   output logic             stall,
   output logic             bubble,
   output logic [SEL_W-1:0] fwd_a,
   output logic [SEL_W-1:0] fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                c_FC_W    = 4;
   localparam logic [c_FC_W-1:0] c_FC_INIT = c_FC_W'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_LDSTALL = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   // Tracking table: index 1 is the stage right after decode (X)
   logic [FWD_STAGES:1] r_v;
   logic [FWD_STAGES:1] r_wr;
   logic [FWD_STAGES:1] r_ld;
   logic [REG_W-1:0]    r_rd [1:FWD_STAGES];

   state_t              r_state;
   logic [c_FC_W-1:0]   r_fc;
   logic [CNT_W-1:0]    r_stallCnt;
   logic [CNT_W-1:0]    r_flushCnt;

   logic [FWD_STAGES:1] w_hitA;
   logic [FWD_STAGES:1] w_hitB;
   logic [SEL_W-1:0]    w_fwdA;
   logic [SEL_W-1:0]    w_fwdB;
   logic                w_ldUseA;
   logic                w_ldUseB;
   logic                w_loadUse;
   logic                w_squash;
   logic                w_stall;
   logic                w_bubble;

   for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_match
      logic w_live;
      assign w_live    = r_v[k] & r_wr[k];
      assign w_hitA[k] = w_live & dec_use_rs1 & (dec_rs1 != '0) & (r_rd[k] == dec_rs1);
      assign w_hitB[k] = w_live & dec_use_rs2 & (dec_rs2 != '0) & (r_rd[k] == dec_rs2);
   end

   // Scan oldest to youngest so the youngest producer overwrites the result
   always_comb begin
      w_fwdA   = '0;
      w_fwdB   = '0;
      w_ldUseA = 1'b0;
      w_ldUseB = 1'b0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (w_hitA[k]) begin
            w_fwdA   = SEL_W'(k);
            w_ldUseA = r_ld[k] & (k <= LOAD_LAT);
         end
         if (w_hitB[k]) begin
            w_fwdB   = SEL_W'(k);
            w_ldUseB = r_ld[k] & (k <= LOAD_LAT);
         end
      end
   end

   assign w_loadUse = w_ldUseA | w_ldUseB;
   assign w_squash  = flush | (r_state == S_FLUSH);
   assign w_stall   = w_loadUse & ~w_squash;
   assign w_bubble  = w_squash | w_stall;

   // Gated so a pending flush cannot leak a bubble while reset is held
   assign stall     = rst_n & w_stall;
   assign bubble    = rst_n & w_bubble;
   assign fwd_a     = w_fwdA;
   assign fwd_b     = w_fwdB;
   assign stall_cnt = r_stallCnt;
   assign flush_cnt = r_flushCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v  <= '0;
         r_wr <= '0;
         r_ld <= '0;
         for (int k = 1; k <= FWD_STAGES; k++) begin
            r_rd[k] <= '0;
         end
      end else begin
         r_v[1]  <= dec_valid & ~w_bubble;
         r_wr[1] <= dec_wr;
         r_ld[1] <= dec_is_load;
         r_rd[1] <= dec_rd;
         for (int k = 2; k <= FWD_STAGES; k++) begin
            r_v[k]  <= r_v[k-1];
            r_wr[k] <= r_wr[k-1];
            r_ld[k] <= r_ld[k-1];
            r_rd[k] <= r_rd[k-1];
         end
      end
   end

   // The flush cycle itself is the first squashed slot, so FLUSH covers the rest
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_fc    <= '0;
      end else if (flush) begin
         r_fc    <= c_FC_INIT;
         r_state <= (c_FC_INIT != '0) ? S_FLUSH : S_RUN;
      end else if (r_state == S_FLUSH) begin
         if (r_fc <= c_FC_W'(1)) begin
            r_fc    <= '0;
            r_state <= S_RUN;
         end else begin
            r_fc    <= r_fc - 1'b1;
         end
      end else begin
         r_state <= w_loadUse ? S_LDSTALL : S_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (w_stall && (r_stallCnt != c_CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
         end
         if (w_squash && dec_valid && (r_flushCnt != c_CNT_MAX)) begin
            r_flushCnt <= r_flushCnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
